// File: rtl/bus_cycle_pkg.sv
// Shared types for the 8288-style bus cycle controller.
//   bus_status_t : S2..S0 status codes from the 8088
//   bus_state_t  : T-state machine states
//   strobe_sel_t : one-hot command strobe select (active high)
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    BS_INTA       = 3'b000,
    BS_IO_READ    = 3'b001,
    BS_IO_WRITE   = 3'b010,
    BS_HALT       = 3'b011,
    BS_CODE_FETCH = 3'b100,
    BS_MEM_READ   = 3'b101,
    BS_MEM_WRITE  = 3'b110,
    BS_PASSIVE    = 3'b111
  } bus_status_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4,
    ST_HALT
  } bus_state_t;

  typedef struct packed {
    logic inta;
    logic io_read;
    logic io_write;
    logic mem_read;
    logic mem_write;
  } strobe_sel_t;

  localparam bus_status_t STATUS_PASSIVE = BS_PASSIVE;

endpackage

// File: rtl/bus_status_decode.sv
// Combinational status decoder.
//   status     : in  bus_status_t, S2..S0 for the cycle being started
//   strobe_sel : out one-hot select of the command strobe to assert
//   write      : out 1 for I/O write and memory write cycles
module bus_status_decode
  import bus_cycle_pkg::*;
(
  input  bus_status_t status,
  output strobe_sel_t strobe_sel,
  output logic        write
);

  always_comb begin
    strobe_sel = '0;
    write      = 1'b0;
    case (status)
      BS_INTA:       strobe_sel.inta      = 1'b1;
      BS_IO_READ:    strobe_sel.io_read   = 1'b1;
      BS_IO_WRITE: begin
        strobe_sel.io_write = 1'b1;
        write               = 1'b1;
      end
      BS_CODE_FETCH: strobe_sel.mem_read  = 1'b1;
      BS_MEM_READ:   strobe_sel.mem_read  = 1'b1;
      BS_MEM_WRITE: begin
        strobe_sel.mem_write = 1'b1;
        write                = 1'b1;
      end
      default: ;  // halt and passive drive no strobe
    endcase
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// 8288-style bus cycle controller: samples 8088 status, runs T1..T4/Tw and
// produces ALE, latched address, DT/R, DEN, lock and active-low strobes.
// Optional build macro BUS_TIMEOUT_EN: limits Tw to TIMEOUT_CYCLES cycles
// and pulses bus_timeout on a forced cycle end.
//   clock, reset_n            : bus clock, async active-low reset
//   processor_status[2:0]     : S2..S0
//   processor_lock_n          : LOCK prefix
//   cpu_address[19:0]         : multiplexed address, valid in T1
//   processor_ready           : synchronized READY, sampled in T3/Tw
//   cpu_bus_enable            : 1 = CPU owns the bus
//   address[19:0]             : address latched at end of T1
//   address_latch_enable      : ALE, high in T1
//   *_n strobes               : IORC/IOWC/MRDC/MWTC/INTA, active low
//   data_enable               : DEN
//   transmit_or_receive_n     : DT/R, 1 = write
//   bus_lock_n                : registered lock
//   halted                    : halt cycle in progress
//   bus_timeout               : one-cycle forced-end pulse
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  processor_status,
  input  logic        processor_lock_n,
  input  logic [19:0] cpu_address,
  input  logic        processor_ready,
  input  logic        cpu_bus_enable,
  output logic [19:0] address,
  output logic        address_latch_enable,
  output logic        io_read_n,
  output logic        io_write_n,
  output logic        memory_read_n,
  output logic        memory_write_n,
  output logic        interrupt_acknowledge_n,
  output logic        data_enable,
  output logic        transmit_or_receive_n,
  output logic        bus_lock_n,
  output logic        halted,
  output logic        bus_timeout
);

  bus_state_t  state;
  bus_status_t cur_status;
  bus_status_t prev_status;
  bus_status_t held_type;
  bus_status_t start_type;
  logic        pending;
  logic        status_edge;
  logic        start;
  logic        abort;
  logic        timeout_hit;
  logic        start_write;
  strobe_sel_t start_sel;
  strobe_sel_t cycle_sel;
  strobe_sel_t strobe_q;
  logic        den_q;

  assign cur_status  = bus_status_t'(processor_status);
  assign status_edge = (prev_status == STATUS_PASSIVE) && (cur_status != STATUS_PASSIVE);
  // An edge seen while DMA owns the bus is parked in pending/held_type
  // and launched once cpu_bus_enable returns.
  assign start       = (state == ST_IDLE) && cpu_bus_enable && (status_edge || pending);
  assign start_type  = pending ? held_type : cur_status;
  assign abort       = !cpu_bus_enable &&
                       ((state == ST_T2) || (state == ST_T3) || (state == ST_TW));

  bus_status_decode u_decode (
    .status     (start_type),
    .strobe_sel (start_sel),
    .write      (start_write)
  );

`ifdef BUS_TIMEOUT_EN
  logic [31:0] tw_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tw_count <= '0;
    end else if (state == ST_T1) begin
      tw_count <= '0;
    end else if (state == ST_TW) begin
      tw_count <= tw_count + 32'd1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th Tw cycle if READY is still low.
  assign timeout_hit = (state == ST_TW) && !processor_ready &&
                       (tw_count == TIMEOUT_CYCLES - 32'd1);
`else
  // No timeout counter: Tw waits indefinitely and the parameter is inert.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // Strobes and DEN are registered, but loss of bus ownership in T2..Tw
  // must release them in the same cycle, hence the combinational abort gate.
  assign interrupt_acknowledge_n = !(strobe_q.inta      && !abort);
  assign io_read_n               = !(strobe_q.io_read   && !abort);
  assign io_write_n              = !(strobe_q.io_write  && !abort);
  assign memory_read_n           = !(strobe_q.mem_read  && !abort);
  assign memory_write_n          = !(strobe_q.mem_write && !abort);
  assign data_enable             = den_q && !abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      prev_status           <= STATUS_PASSIVE;
      held_type             <= STATUS_PASSIVE;
      pending               <= 1'b0;
      cycle_sel             <= '0;
      strobe_q              <= '0;
      den_q                 <= 1'b0;
      address               <= '0;
      address_latch_enable  <= 1'b0;
      transmit_or_receive_n <= 1'b0;
      bus_lock_n            <= 1'b1;
      halted                <= 1'b0;
      bus_timeout           <= 1'b0;
    end else begin
      prev_status <= cur_status;
      bus_timeout <= 1'b0;
      if ((state == ST_IDLE) || (state == ST_T1)) begin
        bus_lock_n <= processor_lock_n;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state                 <= ST_T1;
            pending               <= 1'b0;
            address_latch_enable  <= 1'b1;
            cycle_sel             <= start_sel;
            transmit_or_receive_n <= start_write;
            halted                <= (start_type == BS_HALT);
          end else if (status_edge && !cpu_bus_enable && !pending) begin
            pending   <= 1'b1;
            held_type <= cur_status;
          end
        end
        ST_T1: begin
          address_latch_enable <= 1'b0;
          address              <= cpu_address;
          if (halted) begin
            state <= ST_HALT;
          end else begin
            state    <= ST_T2;
            strobe_q <= cycle_sel;
            den_q    <= 1'b1;
          end
        end
        ST_T2: begin
          if (abort) begin
            state    <= ST_T4;
            strobe_q <= '0;
            den_q    <= 1'b0;
          end else begin
            state <= ST_T3;
          end
        end
        ST_T3, ST_TW: begin
          if (abort || processor_ready || timeout_hit) begin
            state       <= ST_T4;
            strobe_q    <= '0;
            den_q       <= 1'b0;
            bus_timeout <= timeout_hit && !abort;
          end else begin
            state <= ST_TW;
          end
        end
        ST_T4: begin
          state                 <= ST_IDLE;
          transmit_or_receive_n <= 1'b0;
        end
        ST_HALT: begin
          if (cur_status == STATUS_PASSIVE) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Randomized self-checking bench for bus_cycle_controller. Expected outputs
// are derived per bus transaction from its start cycle, deferral, wait count
// and abort point. Define BUS_TIMEOUT_EN to also cover the timeout option.
module tb_bus_cycle_controller;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic [19:0] cpu_address;
  logic        processor_ready;
  logic        cpu_bus_enable;
  logic [19:0] address;
  logic        address_latch_enable;
  logic        io_read_n;
  logic        io_write_n;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        interrupt_acknowledge_n;
  logic        data_enable;
  logic        transmit_or_receive_n;
  logic        bus_lock_n;
  logic        halted;
  logic        bus_timeout;

  int unsigned n_vec;
  int unsigned n_bad;
  logic [19:0] exp_addr;
  logic        exp_lock;

  bus_cycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .processor_status        (processor_status),
    .processor_lock_n        (processor_lock_n),
    .cpu_address             (cpu_address),
    .processor_ready         (processor_ready),
    .cpu_bus_enable          (cpu_bus_enable),
    .address                 (address),
    .address_latch_enable    (address_latch_enable),
    .io_read_n               (io_read_n),
    .io_write_n              (io_write_n),
    .memory_read_n           (memory_read_n),
    .memory_write_n          (memory_write_n),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .data_enable             (data_enable),
    .transmit_or_receive_n   (transmit_or_receive_n),
    .bus_lock_n              (bus_lock_n),
    .halted                  (halted),
    .bus_timeout             (bus_timeout)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Strobe order {INTA, IORC, IOWC, MRDC, MWTC}, active high.
  function automatic logic [4:0] strobe_mask(input logic [2:0] st);
    case (st)
      3'b000:         return 5'b10000;
      3'b001:         return 5'b01000;
      3'b010:         return 5'b00100;
      3'b100, 3'b101: return 5'b00010;
      3'b110:         return 5'b00001;
      default:        return 5'b00000;
    endcase
  endfunction

  task automatic check_outputs(input logic e_ale, input logic [4:0] e_strb_n,
                               input logic e_den, input logic e_dtr,
                               input logic e_halt, input logic e_to);
    check_value("ale", 32'(address_latch_enable), 32'(e_ale));
    check_value("address", 32'(address), 32'(exp_addr));
    check_value("strobes_n", 32'({interrupt_acknowledge_n, io_read_n, io_write_n,
                                  memory_read_n, memory_write_n}), 32'(e_strb_n));
    check_value("den", 32'(data_enable), 32'(e_den));
    check_value("dtr", 32'(transmit_or_receive_n), 32'(e_dtr));
    check_value("lock_n", 32'(bus_lock_n), 32'(exp_lock));
    check_value("halted", 32'(halted), 32'(e_halt));
    check_value("timeout", 32'(bus_timeout), 32'(e_to));
  endtask

  task automatic step(input logic [2:0] st, input logic lk, input logic [19:0] ad,
                      input logic rdy, input logic en);
    @(posedge clock);
    #1;
    processor_status = st;
    processor_lock_n = lk;
    cpu_address      = ad;
    processor_ready  = rdy;
    cpu_bus_enable   = en;
    @(negedge clock);
  endtask

  // One bus transaction. Cycle c=0 is the first active status cycle.
  // d: cycles the bus is held by DMA first; w: not-ready cycles from T3;
  // a_off: abort cycle offset from T2 (-1 = none); hold: extra halt cycles.
  task automatic run_txn(input logic [2:0] st, input logic [19:0] ad, input int d,
                         input int w, input int a_off, input int hold);
    int s, weff, t4, last, a, m;
    bit to_hit, aborted, is_halt;
    logic [4:0] mask;
    logic wr;
    s       = d + 1;
    is_halt = (st == 3'b011);
    mask    = strobe_mask(st);
    wr      = (st == 3'b010) || (st == 3'b110);
    weff    = w;
    to_hit  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    if (w > int'(TO)) begin
      weff   = int'(TO);
      to_hit = 1'b1;
    end
`endif
    aborted = !is_halt && (a_off >= 0);
    a       = s + 1 + a_off;
    if (aborted) begin
      t4     = a + 1;
      to_hit = 1'b0;
    end else begin
      t4 = s + 3 + weff;
    end
    m    = s + 1 + hold;
    last = is_halt ? m + 1 : t4 + 1;
    for (int c = 0; c <= last; c++) begin
      logic [2:0]  cs;
      logic        lk, rdy, en, act;
      logic [19:0] ca;
      lk  = 1'($urandom);
      ca  = (c == s) ? ad : 20'($urandom);
      en  = !((c < d) || (aborted && c == a));
      rdy = (c >= s + 2 && c < s + 2 + w) ? 1'b0 :
            (c == s + 2 + w) ? 1'b1 : 1'($urandom);
      if (is_halt)     cs = (c < m) ? st : 3'b111;
      else if (c <= s) cs = st;
      else if (c <= t4) cs = 3'($urandom);
      else             cs = 3'b111;
      step(cs, lk, ca, rdy, en);
      act = !is_halt && (c > s) && (c <= s + 2 + weff) && !(aborted && c >= a);
      check_outputs(c == s, ~(act ? mask : 5'b0), act, wr && c >= s && c <= t4,
                    is_halt && c >= s && c <= m, to_hit && c == t4);
      if (c <= s || c == last) exp_lock = lk;
      if (c == s) exp_addr = ca;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, d, w, a_off, hold, wcap;
    n_vec = 0;
    n_bad = 0;
    reset_n          = 1'b0;
    processor_status = 3'b111;
    processor_lock_n = 1'b1;
    cpu_address      = '0;
    processor_ready  = 1'b1;
    cpu_bus_enable   = 1'b1;
    exp_addr         = '0;
    exp_lock         = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs(1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_outputs(1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0);

    run_txn(3'b101, 20'hF0000, 0, 0, -1, 0);  // memory read, zero wait
    run_txn(3'b010, 20'h00061, 0, 3, -1, 0);  // I/O write, 3 waits
    run_txn(3'b011, 20'h2468A, 0, 0, -1, 3);  // halt
    run_txn(3'b110, 20'h13579, 0, 3, 2, 0);   // memory write, bus lost in TW
    run_txn(3'b101, 20'hABCDE, 0, 7, -1, 0);  // long wait / timeout
    run_txn(3'b100, 20'h0FFFF, 2, 1, -1, 0);  // deferred start
    run_txn(3'b000, 20'h00000, 0, 0, -1, 0);  // back-to-back INTA
    run_txn(3'b000, 20'h00000, 0, 1, -1, 0);

    // Reset during T3 of an INTA cycle.
    step(3'b000, 1'b1, 20'h12345, 1'b1, 1'b1);
    step(3'b000, 1'b1, 20'h12345, 1'b1, 1'b1);
    step(3'b000, 1'b1, 20'h12345, 1'b0, 1'b1);
    check_value("inta_t2", 32'(interrupt_acknowledge_n), 32'd0);
    step(3'b000, 1'b1, 20'h12345, 1'b0, 1'b1);
    check_value("inta_t3", 32'(interrupt_acknowledge_n), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    exp_addr = '0;
    exp_lock = 1'b1;
    check_outputs(1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    processor_status = 3'b111;
    processor_lock_n = 1'b1;
    reset_n          = 1'b1;
    @(negedge clock);
    check_outputs(1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      st    = int'($urandom_range(0, 6));
      d     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      w     = int'($urandom_range(0, 6));
      wcap  = (w > int'(TO)) ? int'(TO) : w;
      a_off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32'(1 + wcap))) : -1;
      hold  = int'($urandom_range(0, 3));
      run_txn(3'(st), 20'($urandom), d, w, a_off, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
